// File: rtl/usbf_rx_byte_packer.sv
// USB RX byte packer: packs one received data packet into FIFO words (w_clk domain).
// Optional CRC16 residual check when USBF_RX_CRC16_EN is defined.
//
// Ports:
//   w_clk, rst_n        clock, asynchronous active-low reset
//   rx_valid/rx_data    decoded byte stream; rx_sop marks the first byte
//   rx_eop              end-of-packet pulse (no data); rx_err aborts the packet
//   fifo_full           registered FIFO full flag
//   fifo_din/fifo_w_en  packed little-endian word and its write strobe
//   fifo_w_flush        one-cycle write-side flush on abort
//   pkt_done/pkt_ok     packet-complete pulse and its status qualifier
//   pkt_len/pkt_ovf     data byte count and overflow flag of the last packet
//
// Configuration macro: USBF_RX_CRC16_EN (CRC16 residual check, pkt_len excludes CRC bytes).

module usbf_rx_byte_packer #(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 11,
    parameter int MAX_LEN = 1026
) (
    input  logic              w_clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_sop,
    input  logic              rx_eop,
    input  logic              rx_err,
    input  logic              fifo_full,
    output logic [DATA_W-1:0] fifo_din,
    output logic              fifo_w_en,
    output logic              fifo_w_flush,
    output logic              pkt_done,
    output logic              pkt_ok,
    output logic [LEN_W-1:0]  pkt_len,
    output logic              pkt_ovf
);

    localparam int BPW    = DATA_W / 8;
    localparam int LANE_W = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BPW - 1);
    localparam logic [LEN_W-1:0]  MAX_CNT   = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]  SAT_CNT   = LEN_W'(MAX_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_TAIL,
        S_DONE,
        S_ABORT
    } state_t;

    state_t state;
    state_t state_nx;

    logic [LANE_W-1:0] lane;
    logic [LEN_W-1:0]  count;
    logic [DATA_W-1:0] wbuf;
    logic              ovf;
    logic              len_err;

    logic              in_recv;
    logic              sop_take;
    logic              abort_req;
    logic              eop_req;
    logic              byte_req;
    logic              len_full;
    logic              byte_take;
    logic [LANE_W-1:0] cur_lane;
    logic [DATA_W-1:0] word_fill;
    logic              word_done;
    logic              tail_wr;
    logic              wr_req;
    logic [DATA_W-1:0] wr_word;
    logic              ok_nx;
    logic [LEN_W-1:0]  len_nx;

`ifdef USBF_RX_CRC16_EN
    logic [15:0] crc;

    // Reflected CRC16 (poly 0xA001), one byte LSB first.
    function automatic logic [15:0] crc16_upd(
        input logic [15:0] c,
        input logic [7:0]  d
    );
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) begin
                r = (r >> 1) ^ 16'hA001;
            end else begin
                r = r >> 1;
            end
        end
        return r;
    endfunction
`endif

    // Input qualification and byte-lane merge.
    always_comb begin
        in_recv   = (state == S_RECV);
        sop_take  = (state == S_IDLE) & rx_valid & rx_sop
                  & ~rx_eop & ~rx_err;
        abort_req = in_recv & (rx_err | rx_sop);
        eop_req   = in_recv & rx_eop & ~abort_req;
        byte_req  = in_recv & rx_valid & ~rx_eop
                  & ~rx_err & ~rx_sop;
        len_full  = (count >= MAX_CNT);
        byte_take = sop_take | (byte_req & ~len_full);

        // A new packet always starts from an empty word in lane 0.
        cur_lane  = sop_take ? '0 : lane;
        word_fill = sop_take ? '0 : wbuf;
        for (int i = 0; i < BPW; i++) begin
            if (cur_lane == LANE_W'(i)) begin
                word_fill[8*i +: 8] = rx_data;
            end
        end

        word_done = byte_take & (cur_lane == LAST_LANE);
        // A packet that overran its length never flushes its tail.
        tail_wr   = eop_req & (lane != '0) & ~len_err;
        wr_req    = word_done | tail_wr;
        wr_word   = word_done ? word_fill : wbuf;
    end

    // Final status, evaluated while in TAIL.
    always_comb begin
`ifdef USBF_RX_CRC16_EN
        ok_nx  = ~ovf & ~len_err
               & (crc == 16'hB001)
               & (count >= LEN_W'(2));
        len_nx = (count >= LEN_W'(2)) ?
                 count - LEN_W'(2) : '0;
`else
        ok_nx  = ~ovf & ~len_err;
        len_nx = count;
`endif
    end

    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (sop_take) begin
                    state_nx = S_RECV;
                end
            end
            S_RECV: begin
                if (abort_req) begin
                    state_nx = S_ABORT;
                end else if (eop_req) begin
                    state_nx = S_TAIL;
                end
            end
            S_TAIL:  state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            S_ABORT: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Packing datapath and per-packet bookkeeping.
    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            lane    <= '0;
            count   <= '0;
            wbuf    <= '0;
            ovf     <= 1'b0;
            len_err <= 1'b0;
        end else begin
            if (byte_take) begin
                lane <= word_done ? '0 : cur_lane + 1'b1;
                wbuf <= word_done ? '0 : word_fill;
            end else if (eop_req | abort_req) begin
                lane <= '0;
                wbuf <= '0;
            end

            if (sop_take) begin
                count   <= LEN_W'(1);
                len_err <= 1'b0;
                ovf     <= wr_req & fifo_full;
            end else begin
                if (byte_take) begin
                    count <= count + 1'b1;
                end else if (byte_req & len_full) begin
                    count <= SAT_CNT;
                end
                len_err <= len_err | (byte_req & len_full);
                ovf     <= ovf | (wr_req & fifo_full);
            end
        end
    end

`ifdef USBF_RX_CRC16_EN
    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 16'hFFFF;
        end else if (sop_take) begin
            crc <= crc16_upd(16'hFFFF, rx_data);
        end else if (byte_take) begin
            crc <= crc16_upd(crc, rx_data);
        end
    end
`endif

    // Registered outputs. A word is dropped when fifo_full is seen in
    // the cycle its write is decided (the cycle before the strobe).
    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_din     <= '0;
            fifo_w_en    <= 1'b0;
            fifo_w_flush <= 1'b0;
            pkt_done     <= 1'b0;
            pkt_ok       <= 1'b0;
            pkt_len      <= '0;
            pkt_ovf      <= 1'b0;
        end else begin
            fifo_w_en    <= wr_req & ~fifo_full;
            fifo_w_flush <= abort_req;
            pkt_done     <= abort_req | (state == S_TAIL);
            pkt_ok       <= 1'b0;
            if (wr_req) begin
                fifo_din <= wr_word;
            end
            if (abort_req) begin
                pkt_len <= count;
                pkt_ovf <= ovf;
            end else if (state == S_TAIL) begin
                pkt_ok  <= ok_nx;
                pkt_len <= len_nx;
                pkt_ovf <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_usbf_rx_byte_packer.sv
// Bench for usbf_rx_byte_packer: table vectors, corner sequences,
// randomized packets against a packet-level reference model.
`timescale 1ns/1ps

module tb_usbf_rx_byte_packer;

    logic        w_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_sop = 1'b0;
    logic        rx_eop = 1'b0;
    logic        rx_err = 1'b0;
    logic        fifo_full = 1'b0;

    logic [31:0] a_din, b_din;
    logic        a_wen, b_wen, a_fl, b_fl, a_done, b_done;
    logic        a_ok, b_ok, a_ovf, b_ovf;
    logic [10:0] a_len, b_len;

    always #5 w_clk = ~w_clk;

    usbf_rx_byte_packer u_dut (
        .w_clk(w_clk), .rst_n(rst_n),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_err(rx_err),
        .fifo_full(fifo_full),
        .fifo_din(a_din), .fifo_w_en(a_wen),
        .fifo_w_flush(a_fl), .pkt_done(a_done),
        .pkt_ok(a_ok), .pkt_len(a_len), .pkt_ovf(a_ovf)
    );

    usbf_rx_byte_packer #(.MAX_LEN(6)) u_small (
        .w_clk(w_clk), .rst_n(rst_n),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_err(rx_err),
        .fifo_full(fifo_full),
        .fifo_din(b_din), .fifo_w_en(b_wen),
        .fifo_w_flush(b_fl), .pkt_done(b_done),
        .pkt_ok(b_ok), .pkt_len(b_len), .pkt_ovf(b_ovf)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge w_clk) cyc <= cyc + 1;

    // Output monitors
    logic [31:0] wa[$], wb[$];
    int da_cnt = 0, db_cnt = 0, fa_cnt = 0, fb_cnt = 0;
    int da_cyc = 0, db_cyc = 0, fa_cyc = 0, fb_cyc = 0;
    logic da_ok = 0, db_ok = 0, da_ovf = 0, db_ovf = 0;
    logic [10:0] da_len = 0, db_len = 0;

    always @(negedge w_clk) begin
        if (a_wen) wa.push_back(a_din);
        if (b_wen) wb.push_back(b_din);
        if (a_done) begin
            da_cnt <= da_cnt + 1; da_cyc <= cyc;
            da_ok <= a_ok; da_len <= a_len; da_ovf <= a_ovf;
        end
        if (b_done) begin
            db_cnt <= db_cnt + 1; db_cyc <= cyc;
            db_ok <= b_ok; db_len <= b_len; db_ovf <= b_ovf;
        end
        if (a_fl) begin fa_cnt <= fa_cnt + 1; fa_cyc <= cyc; end
        if (b_fl) begin fb_cnt <= fb_cnt + 1; fb_cyc <= cyc; end
    end

    task automatic chk(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    // Packet under test and the fifo_full seen on each byte / eop cycle
    logic [7:0] pb[$];
    bit         pf[$];
    bit         pf_eop;
    int         e_cyc;
    int         sa_d, sb_d, sa_f, sb_f;

    function automatic bit fc_hit(input int fc, input int c);
        return (fc >= 0) && (c == fc || c == fc + 1);
    endfunction

    // kind: 0 = eop, 1 = rx_err abort, 2 = rx_sop abort
    task automatic drive_pkt(input int kind, input int full_c,
                             input bit rnd);
        int n;
        int c;
        n = pb.size();
        pf.delete(); wa.delete(); wb.delete();
        sa_d = da_cnt; sb_d = db_cnt; sa_f = fa_cnt; sb_f = fb_cnt;
        c = 0;
        while (c < n) begin
            if (rnd && $urandom_range(0, 4) == 0) begin
                rx_valid = 0; rx_sop = 0;
                fifo_full = ($urandom_range(0, 1) == 1);
                tick();
            end else begin
                rx_valid = 1; rx_data = pb[c]; rx_sop = (c == 0);
                fifo_full = rnd ? ($urandom_range(0, 3) == 0)
                                : fc_hit(full_c, c);
                pf.push_back(fifo_full);
                tick();
                c++;
            end
        end
        rx_sop = 0;
        rx_data = 8'($urandom_range(0, 255));
        rx_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b0;
        case (kind)
            0: rx_eop = 1;
            1: rx_err = 1;
            default: begin rx_sop = 1; rx_valid = 1; end
        endcase
        fifo_full = rnd ? ($urandom_range(0, 3) == 0) : fc_hit(full_c, n);
        pf_eop = fifo_full;
        e_cyc = cyc;
        tick();
        rx_eop = 0; rx_err = 0; rx_sop = 0;
        // Junk bytes (no sop) while the packet is being closed
        for (int j = 1; j <= 2; j++) begin
            rx_valid = 1;
            rx_data = 8'($urandom_range(0, 255));
            fifo_full = rnd ? ($urandom_range(0, 1) == 1)
                            : fc_hit(full_c, n + j);
            tick();
        end
        rx_valid = 0; fifo_full = 0;
        tick();
        tick();
    endtask

    function automatic logic [15:0] crc16(input logic [15:0] c,
                                          input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    // Expected results
    logic [31:0] ew[$];
    bit e_ok, e_ovf;
    int e_len, e_lat, e_fl;

    task automatic model(input int maxlen, input int kind);
        int n, acc, cnt, nw, rem;
        bit lerr;
        logic [31:0] w;
        logic [15:0] crc;
        n = pb.size();
        lerr = n > maxlen;
        acc = lerr ? maxlen : n;
        cnt = lerr ? maxlen + 1 : n;
        nw = acc / 4;
        rem = acc % 4;
        ew.delete();
        e_ovf = 0;
        for (int k = 0; k < nw; k++) begin
            w = {pb[4*k+3], pb[4*k+2], pb[4*k+1], pb[4*k]};
            if (pf[4*k+3]) e_ovf = 1;
            else ew.push_back(w);
        end
        if (kind == 0 && rem != 0 && !lerr) begin
            w = 32'h0;
            for (int b = 0; b < rem; b++) w[8*b +: 8] = pb[4*nw + b];
            if (pf_eop) e_ovf = 1;
            else ew.push_back(w);
        end
        if (kind == 0) begin
            e_ok = !e_ovf && !lerr;
            e_len = cnt;
`ifdef USBF_RX_CRC16_EN
            crc = 16'hFFFF;
            for (int b = 0; b < acc; b++) crc = crc16(crc, pb[b]);
            e_ok = e_ok && (crc == 16'hB001) && (cnt >= 2);
            e_len = (cnt >= 2) ? cnt - 2 : 0;
`else
            crc = 16'h0;
`endif
            e_lat = 2;
            e_fl = 0;
        end else begin
            e_ok = 0;
            e_len = cnt;
            e_lat = 1;
            e_fl = 1;
        end
    endtask

    task automatic cmp_inst(input string tag, input logic [31:0] q[$],
                            input int d0, input int d, input int dcyc,
                            input int f0, input int f, input int fcyc,
                            input logic ok, input logic [10:0] len,
                            input logic ovf);
        chk({tag, ".nwr"}, q.size(), ew.size());
        for (int i = 0; i < ew.size() && i < q.size(); i++)
            chk({tag, ".word"}, q[i], ew[i]);
        chk({tag, ".ndone"}, d - d0, 1);
        chk({tag, ".ok"}, 32'(ok), 32'(e_ok));
        chk({tag, ".len"}, 32'(len), e_len);
        chk({tag, ".ovf"}, 32'(ovf), 32'(e_ovf));
        chk({tag, ".nflush"}, f - f0, e_fl);
        chk({tag, ".lat"}, dcyc - e_cyc, e_lat);
        if (e_fl != 0) chk({tag, ".flat"}, fcyc - e_cyc, 1);
    endtask

    task automatic cmp_a(input string tag);
        cmp_inst(tag, wa, sa_d, da_cnt, da_cyc, sa_f, fa_cnt, fa_cyc,
                 da_ok, da_len, da_ovf);
    endtask

    task automatic cmp_b(input string tag);
        cmp_inst(tag, wb, sb_d, db_cnt, db_cyc, sb_f, fb_cnt, fb_cyc,
                 db_ok, db_len, db_ovf);
    endtask

    typedef struct {
        int          n;
        int          base;
        int          full_c;
        int          kind;
        int          exp_wr;
        logic [31:0] exp_last;
        bit          exp_ok;
        int          exp_len;
        bit          exp_ovf;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [31:0] last;
        int f0, g0;

        tbl[0] = '{1, 'hA0, -1, 0, 1, 32'h000000A0, 1, 1, 0};
        tbl[1] = '{4, 'h10, -1, 0, 1, 32'h13121110, 1, 4, 0};
        tbl[2] = '{8, 'h01, -1, 0, 2, 32'h08070605, 1, 8, 0};
        tbl[3] = '{8, 'h01, 7, 0, 1, 32'h04030201, 0, 8, 1};
        tbl[4] = '{5, 'h01, -1, 1, 1, 32'h04030201, 0, 5, 0};
        tbl[5] = '{6, 'hFE, -1, 0, 2, 32'h00000302, 1, 6, 0};
        tbl[6] = '{7, 'h40, 7, 0, 1, 32'h43424140, 0, 7, 1};
        tbl[7] = '{2, 'h20, -1, 2, 0, 32'h00000000, 0, 2, 0};
        tbl[8] = '{3, 'hC0, 3, 0, 0, 32'h00000000, 0, 3, 1};

        // Reset state
        repeat (3) @(posedge w_clk);
        #1;
        chk("rst.din", a_din, 32'h0);
        chk("rst.wen", 32'(a_wen), 0);
        chk("rst.flush", 32'(a_fl), 0);
        chk("rst.done", 32'(a_done), 0);
        chk("rst.ok", 32'(a_ok), 0);
        chk("rst.len", 32'(a_len), 0);
        chk("rst.ovf", 32'(a_ovf), 0);
        chk("rst.b_done", 32'(b_done), 0);
        rst_n = 1;
        tick();
        // Idle bytes without sop must be ignored
        rx_valid = 1; rx_data = 8'h55;
        tick(); tick();
        rx_valid = 0;
        tick();
        chk("idle.nwr", wa.size(), 0);
        chk("idle.ndone", da_cnt, 0);

        // Table vectors
        for (int r = 0; r < 9; r++) begin
            vec_t v;
            v = tbl[r];
`ifdef USBF_RX_CRC16_EN
            if (v.kind == 0) begin
                v.exp_ok = 0;
                v.exp_len = (v.exp_len >= 2) ? v.exp_len - 2 : 0;
            end
`endif
            pb.delete();
            for (int i = 0; i < v.n; i++) pb.push_back(8'(v.base + i));
            drive_pkt(v.kind, v.full_c, 0);
            last = (wa.size() > 0) ? wa[wa.size() - 1] : 32'h0;
            chk($sformatf("tbl%0d.nwr", r), wa.size(), v.exp_wr);
            chk($sformatf("tbl%0d.last", r), last, v.exp_last);
            chk($sformatf("tbl%0d.ndone", r), da_cnt - sa_d, 1);
            chk($sformatf("tbl%0d.ok", r), 32'(da_ok), 32'(v.exp_ok));
            chk($sformatf("tbl%0d.len", r), 32'(da_len), v.exp_len);
            chk($sformatf("tbl%0d.ovf", r), 32'(da_ovf), 32'(v.exp_ovf));
            chk($sformatf("tbl%0d.nflush", r), fa_cnt - sa_f,
                (v.kind != 0) ? 1 : 0);
            chk($sformatf("tbl%0d.lat", r), da_cyc - e_cyc,
                (v.kind != 0) ? 1 : 2);
        end

`ifdef USBF_RX_CRC16_EN
        // Known-good CRC16 packet, then a corrupted copy
        pb = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
               8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
        drive_pkt(0, -1, 0);
        ew = '{32'h34333231, 32'h38373635, 32'h00B4C839};
        e_ok = 1; e_len = 9; e_ovf = 0; e_fl = 0; e_lat = 2;
        cmp_a("crc_good");
        pb[4] = 8'h36;
        drive_pkt(0, -1, 0);
        ew = '{32'h34333231, 32'h38373636, 32'h00B4C839};
        e_ok = 0;
        cmp_a("crc_bad");
`endif

        // Length overrun on the MAX_LEN=6 instance, then recovery
        pb.delete();
        for (int i = 0; i < 8; i++) pb.push_back(8'(8'h61 + i));
        drive_pkt(0, -1, 0);
        ew = '{32'h64636261};
        e_ovf = 0; e_fl = 0; e_lat = 2; e_ok = 0;
`ifdef USBF_RX_CRC16_EN
        e_len = 5;
`else
        e_len = 7;
`endif
        cmp_b("lenerr");
        pb = '{8'h31, 8'h32, 8'h33};
        drive_pkt(0, -1, 0);
        ew = '{32'h00333231};
`ifdef USBF_RX_CRC16_EN
        e_ok = 0; e_len = 1;
`else
        e_ok = 1; e_len = 3;
`endif
        cmp_b("after_lenerr");

        // Asynchronous reset in the middle of a packet
        for (int i = 0; i < 3; i++) begin
            rx_valid = 1; rx_data = 8'(8'h70 + i); rx_sop = (i == 0);
            tick();
        end
        rx_valid = 0; rx_sop = 0;
        f0 = fa_cnt; g0 = fb_cnt;
        #2 rst_n = 0;
        #1;
        chk("arst.len", 32'(a_len), 0);
        chk("arst.b_len", 32'(b_len), 0);
        chk("arst.done", 32'(a_done), 0);
        tick(); tick();
        chk("arst.noflush", fa_cnt - f0, 0);
        chk("arst.b_noflush", fb_cnt - g0, 0);
        rst_n = 1;
        tick();
        pb = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        drive_pkt(0, -1, 0);
        model(1026, 0);
        cmp_a("post_rst");

        // Randomized packets against the reference model
        for (int t = 0; t < 60; t++) begin
            int n, kind, r;
            n = $urandom_range(1, 20);
            r = $urandom_range(0, 9);
            kind = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            pb.delete();
            for (int i = 0; i < n; i++)
                pb.push_back(8'($urandom_range(0, 255)));
            drive_pkt(kind, -1, 1);
            model(1026, kind);
            cmp_a($sformatf("rnd%0d.a", t));
            model(6, kind);
            cmp_b($sformatf("rnd%0d.b", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
